vga_grid_renderer: RTL and testbench
====================================

# vga_grid_renderer

Parametrised VGA scan generator and tile renderer for the snake game display. It generates both horizontal and vertical timing internally and paints a GRID_W×GRID_H playfield framed by a one-cell border ring. The playfield holds a variable-length snake, an apple and up to N_BAR barriers. Game state is snapshotted once per frame, so updates from game logic never tear the image. `frame_tick` paces the game logic during vertical blanking.

## Interface
- H_ACT, 640, active pixels per line; H_FP 16, H_SYNC 96, H_BP 48
- V_ACT, 480, active lines; V_FP 10, V_SYNC 2, V_BP 33
- GRID_W, 8, playfield columns; GRID_H, 8, playfield rows
- CELL_PX, 42, cell edge in pixels
- ORG_X, 110, left pixel of border ring; ORG_Y, 30, top line of border ring
- SNAKE_LEN, 9, maximum snake segments
- N_BAR, 4, barrier slots
- IDX_W, 8, cell-index width; cell index = row*GRID_W + col
- LEN_W, 4, width of snake_len
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- snake  in  SNAKE_LEN*IDX_W  segment indices; segment 0 (LSBs) is the head
- snake_len  in  LEN_W  number of valid segments, 0..SNAKE_LEN
- apple  in  IDX_W  apple cell index
- apple_en  in  1  apple visible
- barrier  in  N_BAR*IDX_W  barrier cell indices, slot 0 in the LSBs
- barrier_en  in  N_BAR  per-slot barrier enable
- h_sync  out  1  active-low horizontal sync
- v_sync  out  1  active-low vertical sync
- red_out, green_out, blue_out  out  4 each  pixel colour
- frame_tick  out  1  one-clock pulse at the start of vertical blanking

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACT+H_FP+H_SYNC+H_BP.
  - v_cnt runs 0..V_TOTAL-1; it increments when h_cnt wraps, and wraps itself at V_TOTAL-1.
  - Order within each line/frame: active, front porch, sync, back porch.
  - h_sync is low while H_ACT+H_FP ≤ h_cnt < H_ACT+H_FP+H_SYNC; v_sync follows the same rule on v_cnt.
- Snapshot: at h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, all game inputs are copied into shadow registers. Rendering uses only the shadow copies.
- Geometry:
  - The border ring spans x in [ORG_X, ORG_X+(GRID_W+2)*CELL_PX) and y in [ORG_Y, ORG_Y+(GRID_H+2)*CELL_PX).
  - The interior is the ring area minus its outer CELL_PX band.
  - Cell column and row are tracked by a sub-pixel counter (0..CELL_PX-1) plus a cell counter. No dividers or multipliers are used.
- Line builder FSM:
  - States: IDLE, SCAN, DONE.
  - At h_cnt=H_ACT, if the next line falls inside the interior, the FSM moves IDLE→SCAN with row r and row_base = r*GRID_W (row_base is updated incrementally by +GRID_W).
  - SCAN evaluates one object per clock: segments 0..SNAKE_LEN-1, then the apple, then barriers 0..N_BAR-1.
  - An object hits if it is enabled and row_base ≤ idx < row_base+GRID_W. A hit sets bit (idx-row_base) in the matching back bitmap (head, body, apple or barrier).
  - After the last object the FSM goes to DONE.
  - At h_cnt=H_TOTAL-1 the back bitmaps are copied to the front bitmaps and cleared, and the FSM returns to IDLE.
  - If the next line is not interior, front bitmaps load zero.
- Objects ignored: segment k ≥ snake_len; idx ≥ GRID_W*GRID_H; apple_en=0; barrier_en[k]=0. Duplicate indices are harmless because hits are ORed.
- Colour priority inside the interior: head 0F0 > body FFF > apple F00 > barrier 00F > empty 000.
- Other regions: border ring FF0; outside the ring 000; blanking 000.
- Parameter check: SNAKE_LEN+N_BAR+2 ≤ H_TOTAL-H_ACT must hold; elaboration fails otherwise.

## Timing
- Reset values:
  - h_cnt=0, v_cnt=0, FSM=IDLE.
  - h_sync=1, v_sync=1, RGB=0, frame_tick=0.
  - All bitmaps cleared.
  - Shadow snake_len=0, apple_en=0, barrier_en=0.
- Latency: all outputs are registered. Pixel (x,y) appears on RGB one clock after h_cnt=x, v_cnt=y. Syncs are delayed by the same amount, so colour and sync stay aligned.
- frame_tick is high for exactly one clock, at the cycle after h_cnt=0, v_cnt=V_ACT.
- The bitmap for line L is built during horizontal blanking of line L-1 (mod V_TOTAL).
- Input changes take effect on the first frame after the next snapshot. Mid-frame changes are invisible.
- Reset mid-frame: the module restarts at (0,0). The first frame shows the border only; objects appear from the following frame.

## Test plan
- Reset, then run 2 frames with defaults -> h_sync low for exactly 96 clocks per 800; v_sync low for 2 lines per 525; frame_tick once per 420000 clocks.
- Empty state (snake_len=0, apple_en=0, barrier_en=0) -> line y=40 is FF0 for x 110..529. Line y=100: FF0 at x 110..151 and 488..529, 000 at x 152..487.
- snake_len=1, snake[0]=0 -> x 152..193, y 72..113 are 0F0; all other interior pixels are 000.
- Head and apple both at index 9, body segment at 10 -> cell (1,1) is 0F0; cell (1,2) is FFF.
- snake_len=3 with segment 5 = 63, barrier 0 = 70 (out of range) -> segment 5 is not drawn and no barrier is drawn.
- Change apple from 3 to 4 mid-frame -> the current frame still shows the apple at cell 3; the next frame shows it at cell 4.

Source files
------------

// File: rtl/vga_grid_renderer_if.sv
// Game-state inputs and video outputs of the snake playfield renderer.
// The game-logic side is the master; the renderer is the slave.
interface vga_grid_renderer_if #(
   parameter int SNAKE_LEN = 9,
   parameter int N_BAR     = 4,
   parameter int IDX_W     = 8,
   parameter int LEN_W     = 4
);
   logic [SNAKE_LEN*IDX_W-1:0] snake;
   logic [LEN_W-1:0]           snake_len;
   logic [IDX_W-1:0]           apple;
   logic                       apple_en;
   logic [N_BAR*IDX_W-1:0]     barrier;
   logic [N_BAR-1:0]           barrier_en;
   logic                       h_sync;
   logic                       v_sync;
   logic [3:0]                 red_out;
   logic [3:0]                 green_out;
   logic [3:0]                 blue_out;
   logic                       frame_tick;

   modport master (
      output snake, snake_len, apple, apple_en, barrier, barrier_en,
      input  h_sync, v_sync, red_out, green_out, blue_out, frame_tick
   );

   modport slave (
      input  snake, snake_len, apple, apple_en, barrier, barrier_en,
      output h_sync, v_sync, red_out, green_out, blue_out, frame_tick
   );
endinterface

// File: rtl/vga_grid_renderer.sv
// VGA scan generator and snake playfield tile renderer. Game state is
// snapshotted once per frame; each interior line is resolved during the previous line's blanking.
module vga_grid_renderer #(
   parameter int H_ACT     = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACT     = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int GRID_W    = 8,
   parameter int GRID_H    = 8,
   parameter int CELL_PX   = 42,
   parameter int ORG_X     = 110,
   parameter int ORG_Y     = 30,
   parameter int SNAKE_LEN = 9,
   parameter int N_BAR     = 4,
   parameter int IDX_W     = 8,
   parameter int LEN_W     = 4
) (
   input logic clk,
   input logic rst,
   vga_grid_renderer_if.slave bus
);

   localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int RING_W  = (GRID_W + 2) * CELL_PX;
   localparam int RING_H  = (GRID_H + 2) * CELL_PX;
   localparam int N_OBJ   = SNAKE_LEN + 1 + N_BAR;
   localparam int OBJ_W   = $clog2(N_OBJ + 1);
   localparam int SUB_W   = $clog2(CELL_PX + 1);
   localparam int CX_W    = $clog2(GRID_W + 3);
   localparam int CY_W    = $clog2(GRID_H + 3);
   localparam int BW      = IDX_W + 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   typedef enum logic [1:0] {K_HEAD, K_BODY, K_APPLE, K_BAR} kind_t;

   // The whole object scan must finish inside horizontal blanking.
   if (SNAKE_LEN + N_BAR + 2 > H_TOTAL - H_ACT) begin : g_param_check
      $error("vga_grid_renderer: object scan does not fit in horizontal blanking");
   end

   logic [HW-1:0] h_cnt, h_nxt;
   logic [VW-1:0] v_cnt, v_inc;
   logic          h_wrap, v_last, snap;

   // NOTE: every variable assigned in always_comb gets a value first, so no latches are inferred.
   always_comb begin
      h_wrap = (int'(h_cnt) == H_TOTAL - 1);
      v_last = (int'(v_cnt) == V_TOTAL - 1);
      h_nxt  = h_wrap ? '0 : h_cnt + HW'(1);
      v_inc  = v_last ? '0 : v_cnt + VW'(1);
      snap   = h_wrap && v_last;
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_nxt;
         if (h_wrap) v_cnt <= v_inc;
      end
   end

   logic [SUB_W-1:0] x_sub, y_sub, ny_sub;
   logic [CX_W-1:0]  x_cell;
   logic [CY_W-1:0]  y_cell, ny_cell;
   logic [BW-1:0]    y_base, ny_base;
   logic             ny_interior;

   // Column tracking: counters describe the pixel at h_cnt, reloaded at the ring's left edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_sub  <= '0;
         x_cell <= '0;
      end else if (int'(h_nxt) == ORG_X) begin
         x_sub  <= '0;
         x_cell <= '0;
      end else if (int'(x_sub) == CELL_PX - 1) begin
         x_sub  <= '0;
         x_cell <= x_cell + CX_W'(1);
      end else begin
         x_sub <= x_sub + SUB_W'(1);
      end
   end

   // Row tracking for the line after v_cnt; y_base holds (row-1)*GRID_W for interior rows.
   always_comb begin
      ny_sub  = y_sub;
      ny_cell = y_cell;
      ny_base = y_base;
      if (int'(v_inc) == ORG_Y) begin
         ny_sub  = '0;
         ny_cell = '0;
         ny_base = '0;
      end else if (int'(y_sub) == CELL_PX - 1) begin
         ny_sub  = '0;
         ny_cell = y_cell + CY_W'(1);
         if (y_cell != '0) ny_base = y_base + BW'(GRID_W);
      end else begin
         ny_sub = y_sub + SUB_W'(1);
      end
      ny_interior = (int'(v_inc) >= ORG_Y) && (int'(v_inc) < ORG_Y + RING_H) &&
                    (int'(ny_cell) >= 1) && (int'(ny_cell) <= GRID_H);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_sub  <= '0;
         y_cell <= '0;
         y_base <= '0;
      end else if (h_wrap) begin
         y_sub  <= ny_sub;
         y_cell <= ny_cell;
         y_base <= ny_base;
      end
   end

   logic [IDX_W-1:0] snake_sh [SNAKE_LEN];
   logic [IDX_W-1:0] barrier_sh [N_BAR];
   logic [IDX_W-1:0] apple_sh;
   logic [LEN_W-1:0] snake_len_sh;
   logic             apple_en_sh;
   logic [N_BAR-1:0] barrier_en_sh;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snake_len_sh  <= '0;
         apple_en_sh   <= 1'b0;
         barrier_en_sh <= '0;
      end else if (snap) begin
         snake_len_sh  <= bus.snake_len;
         apple_en_sh   <= bus.apple_en;
         barrier_en_sh <= bus.barrier_en;
      end
   end

   // NOTE: index shadows carry no reset; their enables/length gate them until the first snapshot.
   always_ff @(posedge clk) begin
      if (snap) begin
         for (int k = 0; k < SNAKE_LEN; k++) snake_sh[k] <= bus.snake[k*IDX_W +: IDX_W];
         for (int k = 0; k < N_BAR; k++) barrier_sh[k] <= bus.barrier[k*IDX_W +: IDX_W];
         apple_sh <= bus.apple;
      end
   end

   state_t           state, state_nxt;
   logic             start, eval;
   logic [OBJ_W-1:0] obj;
   logic [BW-1:0]    build_base;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      eval      = 1'b0;
      case (state)
         IDLE: if (int'(h_cnt) == H_ACT && ny_interior) begin
            state_nxt = SCAN;
            start     = 1'b1;
         end
         SCAN: begin
            eval = 1'b1;
            if (int'(obj) == N_OBJ - 1) state_nxt = DONE;
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (h_wrap) state_nxt = IDLE;
   end

   logic [IDX_W-1:0]  cur_idx;
   logic              cur_en, in_grid;
   kind_t             cur_kind;
   logic [GRID_W-1:0] hit_vec;

   // Object order: segments 0..SNAKE_LEN-1, apple, barriers 0..N_BAR-1.
   always_comb begin
      cur_idx  = '0;
      cur_en   = 1'b0;
      cur_kind = K_BAR;
      for (int k = 0; k < SNAKE_LEN; k++) begin
         if (int'(obj) == k) begin
            cur_idx  = snake_sh[k];
            cur_en   = (k < int'(snake_len_sh));
            cur_kind = (k == 0) ? K_HEAD : K_BODY;
         end
      end
      if (int'(obj) == SNAKE_LEN) begin
         cur_idx  = apple_sh;
         cur_en   = apple_en_sh;
         cur_kind = K_APPLE;
      end
      for (int k = 0; k < N_BAR; k++) begin
         if (int'(obj) == SNAKE_LEN + 1 + k) begin
            cur_idx  = barrier_sh[k];
            cur_en   = barrier_en_sh[k];
            cur_kind = K_BAR;
         end
      end
      in_grid = (int'(cur_idx) < GRID_W * GRID_H);
      for (int i = 0; i < GRID_W; i++) begin
         hit_vec[i] = eval && cur_en && in_grid && ({1'b0, cur_idx} == build_base + BW'(i));
      end
   end

   logic [GRID_W-1:0] back_head, back_body, back_apple, back_bar;
   logic [GRID_W-1:0] front_head, front_body, front_apple, front_bar;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         obj         <= '0;
         build_base  <= '0;
         back_head   <= '0;
         back_body   <= '0;
         back_apple  <= '0;
         back_bar    <= '0;
         front_head  <= '0;
         front_body  <= '0;
         front_apple <= '0;
         front_bar   <= '0;
      end else begin
         if (start) begin
            obj        <= '0;
            build_base <= ny_base;
         end else if (eval && int'(obj) != N_OBJ - 1) begin
            obj <= obj + OBJ_W'(1);
         end
         // Back bitmaps are only written during SCAN, so a non-interior line swaps in zeros.
         if (h_wrap) begin
            front_head  <= back_head;
            front_body  <= back_body;
            front_apple <= back_apple;
            front_bar   <= back_bar;
            back_head   <= '0;
            back_body   <= '0;
            back_apple  <= '0;
            back_bar    <= '0;
         end else if (eval) begin
            case (cur_kind)
               K_HEAD:  back_head  <= back_head  | hit_vec;
               K_BODY:  back_body  <= back_body  | hit_vec;
               K_APPLE: back_apple <= back_apple | hit_vec;
               K_BAR:   back_bar   <= back_bar   | hit_vec;
            endcase
         end
      end
   end

   logic        active, in_ring, in_int;
   logic        p_head, p_body, p_apple, p_bar;
   logic [11:0] rgb_nxt;

   always_comb begin
      active  = (int'(h_cnt) < H_ACT) && (int'(v_cnt) < V_ACT);
      in_ring = (int'(h_cnt) >= ORG_X) && (int'(h_cnt) < ORG_X + RING_W) &&
                (int'(v_cnt) >= ORG_Y) && (int'(v_cnt) < ORG_Y + RING_H);
      in_int  = in_ring && (int'(x_cell) >= 1) && (int'(x_cell) <= GRID_W) &&
                (int'(y_cell) >= 1) && (int'(y_cell) <= GRID_H);
      p_head  = 1'b0;
      p_body  = 1'b0;
      p_apple = 1'b0;
      p_bar   = 1'b0;
      for (int i = 0; i < GRID_W; i++) begin
         if (int'(x_cell) == i + 1) begin
            p_head  = front_head[i];
            p_body  = front_body[i];
            p_apple = front_apple[i];
            p_bar   = front_bar[i];
         end
      end
      rgb_nxt = 12'h000;
      if (active && in_int) begin
         if (p_head)       rgb_nxt = 12'h0F0;
         else if (p_body)  rgb_nxt = 12'hFFF;
         else if (p_apple) rgb_nxt = 12'hF00;
         else if (p_bar)   rgb_nxt = 12'h00F;
      end else if (active && in_ring) begin
         rgb_nxt = 12'hFF0;
      end
   end

   logic [11:0] rgb_q;
   logic        h_sync_q, v_sync_q, frame_tick_q;

   // Syncs take the same one-clock delay as colour so they stay aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_q        <= '0;
         h_sync_q     <= 1'b1;
         v_sync_q     <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         rgb_q        <= rgb_nxt;
         h_sync_q     <= !((int'(h_cnt) >= H_ACT + H_FP) && (int'(h_cnt) < H_ACT + H_FP + H_SYNC));
         v_sync_q     <= !((int'(v_cnt) >= V_ACT + V_FP) && (int'(v_cnt) < V_ACT + V_FP + V_SYNC));
         frame_tick_q <= (h_cnt == '0) && (int'(v_cnt) == V_ACT);
      end
   end

   assign bus.red_out    = rgb_q[11:8];
   assign bus.green_out  = rgb_q[7:4];
   assign bus.blue_out   = rgb_q[3:0];
   assign bus.h_sync     = h_sync_q;
   assign bus.v_sync     = v_sync_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Scoreboard bench for vga_grid_renderer on a shrunken 40x30 raster with 2-pixel cells.
// Stimulus queues expected pixels by raster position; a monitor pops them as the scan passes.
module tb_vga_grid_renderer;
   localparam int H_ACT = 24, H_FP = 4, H_SYNC = 6, H_BP = 6;
   localparam int V_ACT = 24, V_FP = 2, V_SYNC = 2, V_BP = 2;
   localparam int GRID_W = 8, GRID_H = 8, CELL_PX = 2, ORG_X = 2, ORG_Y = 2;
   localparam int SNAKE_LEN = 9, N_BAR = 4, IDX_W = 8, LEN_W = 4;
   localparam int H_TOTAL = 40, V_TOTAL = 30, FRAME = 1200, N_FRAMES = 6;
   localparam logic [11:0] C_BLK = 12'h000, C_RING = 12'hFF0, C_HEAD = 12'h0F0;
   localparam logic [11:0] C_BODY = 12'hFFF, C_APPLE = 12'hF00, C_BAR = 12'h00F;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vga_grid_renderer_if #(.SNAKE_LEN(SNAKE_LEN), .N_BAR(N_BAR), .IDX_W(IDX_W), .LEN_W(LEN_W)) bus ();

   vga_grid_renderer #(
      .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_PX(CELL_PX), .ORG_X(ORG_X), .ORG_Y(ORG_Y),
      .SNAKE_LEN(SNAKE_LEN), .N_BAR(N_BAR), .IDX_W(IDX_W), .LEN_W(LEN_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int          pos;
      logic [11:0] rgb;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   pos_now  = -1;
   bit   mon_done = 1'b0;

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   function automatic void push_px(int f, int x, int y, logic [11:0] c, string nm);
      exp_t e;
      int   i;
      e.pos  = f * FRAME + y * H_TOTAL + x;
      e.rgb  = c;
      e.name = $sformatf("%s f%0d (%0d,%0d)", nm, f, x, y);
      i = 0;
      while (i < exp_q.size() && exp_q[i].pos <= e.pos) i++;
      exp_q.insert(i, e);
   endfunction

   function automatic void push_cell(int f, int col, int row, logic [11:0] c, string nm);
      for (int dy = 0; dy < CELL_PX; dy++)
         for (int dx = 0; dx < CELL_PX; dx++)
            push_px(f, ORG_X + CELL_PX * (col + 1) + dx, ORG_Y + CELL_PX * (row + 1) + dy, c, nm);
   endfunction

   task automatic set_seg(int k, logic [IDX_W-1:0] v);
      bus.snake[k*IDX_W +: IDX_W] = v;
   endtask

   task automatic set_bar(int k, logic [IDX_W-1:0] v);
      bus.barrier[k*IDX_W +: IDX_W] = v;
   endtask

   task automatic wait_pos(int k);
      while (pos_now < k) @(negedge clk);
   endtask

   // Monitor: one output pixel per clock, sampled on the falling edge.
   initial begin
      exp_t e;
      int   x, y, hl, vl, tc, tp, sm;
      logic exp_h, exp_v, exp_t_;
      hl = 0; vl = 0; tc = 0; tp = -1; sm = 0;
      @(posedge rst);
      for (int k = 0; k < N_FRAMES * FRAME; k++) begin
         @(negedge clk);
         pos_now = k;
         x = k % H_TOTAL;
         y = (k / H_TOTAL) % V_TOTAL;
         exp_h  = !(x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SYNC);
         exp_v  = !(y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SYNC);
         exp_t_ = (x == 0 && y == V_ACT);
         if (bus.h_sync !== exp_h || bus.v_sync !== exp_v || bus.frame_tick !== exp_t_) sm++;
         if (bus.h_sync === 1'b0) hl++;
         if (bus.v_sync === 1'b0) vl++;
         if (bus.frame_tick === 1'b1) begin
            tc++;
            tp = y * H_TOTAL + x;
         end
         while (exp_q.size() > 0 && exp_q[0].pos <= k) begin
            e = exp_q.pop_front();
            if (e.pos < k) check({e.name, " reached"}, k, e.pos);
            else check(e.name, {bus.red_out, bus.green_out, bus.blue_out}, e.rgb);
         end
         if (x == H_TOTAL - 1 && y == V_TOTAL - 1) begin
            check($sformatf("h_sync low clocks f%0d", k / FRAME), hl, 6 * 30);
            check($sformatf("v_sync low clocks f%0d", k / FRAME), vl, 2 * 40);
            check($sformatf("frame_tick count f%0d", k / FRAME), tc, 1);
            check($sformatf("frame_tick position f%0d", k / FRAME), tp, 960);
            check($sformatf("sync/tick alignment errors f%0d", k / FRAME), sm, 0);
            hl = 0; vl = 0; tc = 0; tp = -1; sm = 0;
         end
      end
      mon_done = 1'b1;
   end

   initial begin
      int guard;
      bus.snake      = '0;
      bus.snake_len  = 4'd1;
      bus.apple      = '0;
      bus.apple_en   = 1'b0;
      bus.barrier    = '0;
      bus.barrier_en = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset h_sync", bus.h_sync, 1);
      check("reset v_sync", bus.v_sync, 1);
      check("reset rgb", {bus.red_out, bus.green_out, bus.blue_out}, 0);
      check("reset frame_tick", bus.frame_tick, 0);

      // Frame 0: shadows still hold reset values, so only the border ring shows.
      for (int x = 2; x <= 21; x++) push_px(0, x, 2, C_RING, "ring top");
      for (int x = 2; x <= 21; x++)
         push_px(0, x, 10, (x <= 3 || x >= 20) ? C_RING : C_BLK, "empty row");
      push_px(0, 0, 0, C_BLK, "outside ring");
      push_px(0, 22, 10, C_BLK, "right of ring");
      push_cell(0, 0, 0, C_BLK, "no objects before snapshot");
      // Frame 1: single head at index 0.
      push_cell(1, 0, 0, C_HEAD, "head idx0");
      push_cell(1, 1, 0, C_BLK, "right of head");
      push_cell(1, 0, 1, C_BLK, "below head");
      push_px(1, 20, 10, C_RING, "ring right");
      push_px(1, 30, 5, C_BLK, "h blank");
      push_px(1, 5, 28, C_BLK, "v blank");
      rst = 1'b1;

      // Frame 2: head and apple share index 9, body at 10.
      wait_pos(FRAME + 100);
      bus.snake_len = 4'd2;
      set_seg(0, 8'd9);
      set_seg(1, 8'd10);
      bus.apple    = 8'd9;
      bus.apple_en = 1'b1;
      push_cell(2, 1, 1, C_HEAD, "head over apple");
      push_cell(2, 2, 1, C_BODY, "body idx10");
      push_cell(2, 0, 0, C_BLK, "old head gone");
      push_cell(2, 3, 1, C_BLK, "after body");

      // Frame 3: length limit, out-of-range and disabled barriers, priorities.
      wait_pos(2 * FRAME + 100);
      bus.snake_len = 4'd3;
      set_seg(0, 8'd20);
      set_seg(1, 8'd21);
      set_seg(2, 8'd22);
      set_seg(3, 8'd0);
      set_seg(4, 8'd1);
      set_seg(5, 8'd63);
      bus.apple = 8'd23;
      set_bar(0, 8'd70);
      set_bar(1, 8'd30);
      set_bar(2, 8'd23);
      set_bar(3, 8'd31);
      bus.barrier_en = 4'b0111;
      push_cell(3, 4, 2, C_HEAD, "head idx20");
      push_cell(3, 5, 2, C_BODY, "body idx21");
      push_cell(3, 6, 2, C_BODY, "body idx22");
      push_cell(3, 7, 2, C_APPLE, "apple over barrier");
      push_cell(3, 6, 3, C_BAR, "barrier idx30");
      push_cell(3, 7, 3, C_BLK, "disabled barrier");
      push_cell(3, 7, 7, C_BLK, "segment beyond len");
      push_cell(3, 0, 0, C_BLK, "seg3 beyond len");
      push_cell(3, 1, 0, C_BLK, "seg4 beyond len");
      push_px(3, 4, 20, C_RING, "ring bottom");

      // Frame 4: apple alone at 3; frame 5 after a mid-frame move to 4.
      wait_pos(3 * FRAME + 100);
      bus.snake_len  = 4'd0;
      bus.apple      = 8'd3;
      bus.barrier_en = 4'b0000;
      push_cell(4, 3, 0, C_APPLE, "apple idx3");
      push_cell(4, 4, 0, C_BLK, "apple not yet at 4");
      wait_pos(4 * FRAME + 2 * H_TOTAL);
      bus.apple = 8'd4;
      push_cell(5, 4, 0, C_APPLE, "apple idx4");
      push_cell(5, 3, 0, C_BLK, "apple left 3");

      wait_pos(N_FRAMES * FRAME - 1);
      guard = 0;
      while (!mon_done && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("monitor finished", mon_done, 1);
      check("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
